// File: rtl/mem_ctrl_if.sv
// CPU-side and bank-side signal bundle for mem_ctrl.
// slave is the controller's view; master is the CPU plus memory banks.
interface mem_ctrl_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int BANK_BITS  = 1
);
    localparam int NUM_BANKS      = 1 << BANK_BITS;
    localparam int MEM_ADDR_WIDTH = ADDR_WIDTH - BANK_BITS;

    logic [ADDR_WIDTH-1:0]     address;
    logic [DATA_WIDTH-1:0]     dataIn;
    logic [DATA_WIDTH-1:0]     dataOut;
    logic                      notRead;
    logic                      notWrite;
    logic                      ready;
    logic                      error;
    logic [MEM_ADDR_WIDTH-1:0] memAddress;
    logic [DATA_WIDTH-1:0]     memDataOut;
    logic [DATA_WIDTH-1:0]     memDataIn;
    logic                      memNotRead;
    logic                      memNotWrite;
    logic [NUM_BANKS-1:0]      memNotSelect;

    modport master (
        output address, dataIn, notRead, notWrite, memDataIn,
        input  dataOut, ready, error, memAddress, memDataOut,
               memNotRead, memNotWrite, memNotSelect
    );

    modport slave (
        input  address, dataIn, notRead, notWrite, memDataIn,
        output dataOut, ready, error, memAddress, memDataOut,
               memNotRead, memNotWrite, memNotSelect
    );
endinterface

// File: rtl/mem_ctrl.sv
// Banked memory controller: CPU strobe handshake, fixed wait states, one-hot bank select.
// Optional MEM_CTRL_ACCESS_COUNT_EN adds a 32-bit completed-access counter output.
//
// state  | meaning
// IDLE   | waiting for a single CPU strobe; both low flags error
// ACCESS | bank selected and strobed for WAIT_STATES+1 cycles
// DONE   | ready high until the CPU releases both strobes
module mem_ctrl #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 16,
    parameter int BANK_BITS   = 1,
    parameter int WAIT_STATES = 2
) (
    input  logic      clock,
    input  logic      reset,
    mem_ctrl_if.slave bus
`ifdef MEM_CTRL_ACCESS_COUNT_EN
    ,
    output logic [31:0] accessCount
`endif
);
    localparam int NUM_BANKS      = 1 << BANK_BITS;
    localparam int MEM_ADDR_WIDTH = ADDR_WIDTH - BANK_BITS;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                state, state_next;
    logic [3:0]            wait_cnt, wait_cnt_next;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  write_q;
    logic                  error_q;
    logic                  rd_req, wr_req, both_low;
    logic                  start, finish, err_set;
    logic                  mem_not_read, mem_not_write, ready_c;
    logic [NUM_BANKS-1:0]  bank_onehot;
    logic [NUM_BANKS-1:0]  mem_not_select;

    assign rd_req   = ~bus.notRead &  bus.notWrite;
    assign wr_req   =  bus.notRead & ~bus.notWrite;
    assign both_low = ~bus.notRead & ~bus.notWrite;

    generate
        if (BANK_BITS == 0) begin : g_single_bank
            assign bank_onehot = 1'b1;
        end else begin : g_multi_bank
            assign bank_onehot = NUM_BANKS'(1) << addr_q[ADDR_WIDTH-1 -: BANK_BITS];
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next     = state;
        wait_cnt_next  = wait_cnt;
        start          = 1'b0;
        finish         = 1'b0;
        err_set        = 1'b0;
        ready_c        = 1'b0;
        mem_not_read   = 1'b1;
        mem_not_write  = 1'b1;
        mem_not_select = '1;
        case (state)
            IDLE: begin
                if (rd_req || wr_req) begin
                    state_next    = ACCESS;
                    wait_cnt_next = 4'(WAIT_STATES);
                    start         = 1'b1;
                end else if (both_low) begin
                    err_set = 1'b1;
                end
            end
            ACCESS: begin
                mem_not_select = ~bank_onehot;
                mem_not_read   = write_q;
                mem_not_write  = ~write_q;
                if (wait_cnt == 4'd0) begin
                    state_next = DONE;
                    finish     = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt - 4'd1;
                end
            end
            DONE: begin
                ready_c = 1'b1;
                if (bus.notRead && bus.notWrite) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            write_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            if (start) begin
                addr_q  <= bus.address;
                wdata_q <= bus.dataIn;
                write_q <= wr_req;
            end
            // Writes must leave the CPU read data untouched.
            if (finish && !write_q) rdata_q <= bus.memDataIn;
            if (err_set) error_q <= 1'b1;
        end
    end

`ifdef MEM_CTRL_ACCESS_COUNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) accessCount <= 32'd0;
        else if (finish) accessCount <= accessCount + 32'd1;
    end
`endif

    assign bus.dataOut      = rdata_q;
    assign bus.ready        = ready_c;
    assign bus.error        = error_q;
    assign bus.memAddress   = addr_q[MEM_ADDR_WIDTH-1:0];
    assign bus.memDataOut   = wdata_q;
    assign bus.memNotRead   = mem_not_read;
    assign bus.memNotWrite  = mem_not_write;
    assign bus.memNotSelect = mem_not_select;
endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: three instances (defaults, zero wait states, four banks),
// table of directed accesses plus error, hold-after-ready and mid-access reset sequences.
module tb_mem_ctrl;
    logic        clock;
    logic        reset;
    logic [15:0] address, dataIn, memDataIn;
    logic [2:0]  nr, nw;
    int          cur;
    int          checks = 0;
    int          errors = 0;

    logic [3:0]  sel_obs;
    logic [15:0] maddr_obs, dout_obs, mdo_obs;
    logic        rdy_obs, err_obs, mnr_obs, mnw_obs;

    mem_ctrl_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .BANK_BITS(1)) bus0 ();
    mem_ctrl_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .BANK_BITS(1)) bus1 ();
    mem_ctrl_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .BANK_BITS(2)) bus2 ();

`ifdef MEM_CTRL_ACCESS_COUNT_EN
    logic [31:0] cnt0, cnt1, cnt2;
`endif

    mem_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .BANK_BITS(1), .WAIT_STATES(2)) dut0 (
        .clock(clock), .reset(reset), .bus(bus0)
`ifdef MEM_CTRL_ACCESS_COUNT_EN
        , .accessCount(cnt0)
`endif
    );
    mem_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .BANK_BITS(1), .WAIT_STATES(0)) dut1 (
        .clock(clock), .reset(reset), .bus(bus1)
`ifdef MEM_CTRL_ACCESS_COUNT_EN
        , .accessCount(cnt1)
`endif
    );
    mem_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .BANK_BITS(2), .WAIT_STATES(2)) dut2 (
        .clock(clock), .reset(reset), .bus(bus2)
`ifdef MEM_CTRL_ACCESS_COUNT_EN
        , .accessCount(cnt2)
`endif
    );

    assign bus0.address = address;  assign bus1.address = address;  assign bus2.address = address;
    assign bus0.dataIn = dataIn;    assign bus1.dataIn = dataIn;    assign bus2.dataIn = dataIn;
    assign bus0.memDataIn = memDataIn; assign bus1.memDataIn = memDataIn; assign bus2.memDataIn = memDataIn;
    assign bus0.notRead = nr[0];    assign bus1.notRead = nr[1];    assign bus2.notRead = nr[2];
    assign bus0.notWrite = nw[0];   assign bus1.notWrite = nw[1];   assign bus2.notWrite = nw[2];

    always_comb begin
        sel_obs = '1; maddr_obs = '0; dout_obs = '0; mdo_obs = '0;
        rdy_obs = 1'b0; err_obs = 1'b0; mnr_obs = 1'b1; mnw_obs = 1'b1;
        case (cur)
            0: begin
                sel_obs = {2'b11, bus0.memNotSelect}; maddr_obs = {1'b0, bus0.memAddress};
                dout_obs = bus0.dataOut; mdo_obs = bus0.memDataOut; rdy_obs = bus0.ready;
                err_obs = bus0.error; mnr_obs = bus0.memNotRead; mnw_obs = bus0.memNotWrite;
            end
            1: begin
                sel_obs = {2'b11, bus1.memNotSelect}; maddr_obs = {1'b0, bus1.memAddress};
                dout_obs = bus1.dataOut; mdo_obs = bus1.memDataOut; rdy_obs = bus1.ready;
                err_obs = bus1.error; mnr_obs = bus1.memNotRead; mnw_obs = bus1.memNotWrite;
            end
            default: begin
                sel_obs = bus2.memNotSelect; maddr_obs = {2'b00, bus2.memAddress};
                dout_obs = bus2.dataOut; mdo_obs = bus2.memDataOut; rdy_obs = bus2.ready;
                err_obs = bus2.error; mnr_obs = bus2.memNotRead; mnw_obs = bus2.memNotWrite;
            end
        endcase
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int          dut;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] din;
        logic [15:0] mdin;
        logic [3:0]  sel;
        logic [15:0] maddr;
        logic [15:0] dout;
        int          cycles;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_vec(input vec_t v, input int idx);
        int          strobe_cyc, other_low, edges;
        logic        got;
        logic [3:0]  sel_seen;
        logic [15:0] maddr_seen, mdo_seen;
        cur = v.dut;
        @(negedge clock);
        address = v.addr; dataIn = v.din; memDataIn = v.mdin;
        if (v.wr) nw[v.dut] = 1'b0; else nr[v.dut] = 1'b0;
        @(posedge clock);
        @(negedge clock);
        // Garbage address/data and the opposite strobe during ACCESS must be ignored.
        address = ~v.addr; dataIn = ~v.din;
        if (v.wr) begin nw[v.dut] = 1'b1; nr[v.dut] = 1'b0; end
        else begin nr[v.dut] = 1'b1; nw[v.dut] = 1'b0; end
        strobe_cyc = 0; other_low = 0; edges = -1; got = 1'b0;
        sel_seen = '1; maddr_seen = '0; mdo_seen = '0;
        for (int n = 1; n <= 20 && !got; n++) begin
            if (rdy_obs) begin
                got = 1'b1; edges = n - 1;
            end else begin
                if ((v.wr ? mnw_obs : mnr_obs) == 1'b0) begin
                    if (strobe_cyc == 0) begin
                        sel_seen = sel_obs; maddr_seen = maddr_obs; mdo_seen = mdo_obs;
                    end
                    strobe_cyc++;
                end
                if ((v.wr ? mnr_obs : mnw_obs) == 1'b0) other_low++;
                @(negedge clock);
                nr = '1; nw = '1;
            end
        end
        nr = '1; nw = '1;
        chk($sformatf("v%0d ready_seen", idx), 32'(got), 32'd1);
        chk($sformatf("v%0d ready_edges", idx), 32'(edges), 32'(v.cycles));
        chk($sformatf("v%0d strobe_cycles", idx), 32'(strobe_cyc), 32'(v.cycles));
        chk($sformatf("v%0d wrong_strobe", idx), 32'(other_low), 32'd0);
        chk($sformatf("v%0d mem_select", idx), 32'(sel_seen), 32'(v.sel));
        chk($sformatf("v%0d mem_address", idx), 32'(maddr_seen), 32'(v.maddr));
        chk($sformatf("v%0d mem_data_out", idx), 32'(mdo_seen), 32'(v.din));
        chk($sformatf("v%0d data_out", idx), 32'(dout_obs), 32'(v.dout));
        chk($sformatf("v%0d done_select", idx), 32'(sel_obs), 32'hF);
        chk($sformatf("v%0d done_strobes", idx), 32'({mnr_obs, mnw_obs}), 32'h3);
        @(negedge clock);
        chk($sformatf("v%0d ready_drop", idx), 32'(rdy_obs), 32'd0);
    endtask

    initial begin
        vecs[0] = '{0, 1'b0, 16'h8004, 16'h0A0A, 16'hBEEF, 4'b1101, 16'h0004, 16'hBEEF, 3};
        vecs[1] = '{0, 1'b0, 16'h0123, 16'h0B0B, 16'h5A5A, 4'b1110, 16'h0123, 16'h5A5A, 3};
        vecs[2] = '{0, 1'b1, 16'hFFFF, 16'h7777, 16'hDEAD, 4'b1101, 16'h7FFF, 16'h5A5A, 3};
        vecs[3] = '{0, 1'b0, 16'h7FFF, 16'h0C0C, 16'h0001, 4'b1110, 16'h7FFF, 16'h0001, 3};
        vecs[4] = '{1, 1'b1, 16'h0010, 16'h1234, 16'hDEAD, 4'b1110, 16'h0010, 16'h0000, 1};
        vecs[5] = '{1, 1'b0, 16'h8004, 16'h0D0D, 16'hCAFE, 4'b1101, 16'h0004, 16'hCAFE, 1};
        vecs[6] = '{2, 1'b0, 16'h0000, 16'h0001, 16'h1111, 4'b1110, 16'h0000, 16'h1111, 3};
        vecs[7] = '{2, 1'b0, 16'h4000, 16'h0002, 16'h2222, 4'b1101, 16'h0000, 16'h2222, 3};
        vecs[8] = '{2, 1'b0, 16'h8000, 16'h0003, 16'h3333, 4'b1011, 16'h0000, 16'h3333, 3};
        vecs[9] = '{2, 1'b0, 16'hC000, 16'h0004, 16'h4444, 4'b0111, 16'h0000, 16'h4444, 3};

        reset = 1'b1; address = '0; dataIn = '0; memDataIn = '0; nr = '1; nw = '1; cur = 0;
        #2;
        for (int d = 0; d < 3; d++) begin
            cur = d;
            #1;
            chk($sformatf("rst%0d select", d), 32'(sel_obs), 32'hF);
            chk($sformatf("rst%0d strobes", d), 32'({mnr_obs, mnw_obs}), 32'h3);
            chk($sformatf("rst%0d ready_error", d), 32'({rdy_obs, err_obs}), 32'h0);
            chk($sformatf("rst%0d data_out", d), 32'(dout_obs), 32'h0);
            chk($sformatf("rst%0d mem_addr_data", d), {maddr_obs, mdo_obs}, 32'h0);
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        cur = 0;
        chk("idle_no_access", 32'({rdy_obs, mnr_obs, mnw_obs}), 32'h3);

        for (int i = 0; i < 10; i++) do_vec(vecs[i], i);

        for (int d = 0; d < 3; d++) begin
            cur = d;
            #1;
            chk($sformatf("no_error%0d", d), 32'(err_obs), 32'd0);
        end
`ifdef MEM_CTRL_ACCESS_COUNT_EN
        chk("access_count1", cnt1, 32'd2);
        chk("access_count2", cnt2, 32'd4);
`endif

        // Both strobes low in IDLE: sticky error, no access.
        cur = 0;
        @(negedge clock);
        nr[0] = 1'b0; nw[0] = 1'b0;
        @(negedge clock);
        chk("err_set", 32'(err_obs), 32'd1);
        chk("err_no_strobe", 32'({mnr_obs, mnw_obs}), 32'h3);
        chk("err_no_select", 32'(sel_obs), 32'hF);
        chk("err_no_ready", 32'(rdy_obs), 32'd0);
        nr = '1; nw = '1;
        do_vec(vecs[0], 10);
        chk("err_sticky", 32'(err_obs), 32'd1);

        // Strobe held after ready: DONE held, no second access.
        cur = 0;
        @(negedge clock);
        address = 16'h0042; memDataIn = 16'h9999; nr[0] = 1'b0;
        begin
            logic seen;
            seen = 1'b0;
            for (int n = 0; n < 20 && !seen; n++) begin
                @(negedge clock);
                if (rdy_obs) seen = 1'b1;
            end
            chk("hold_ready_seen", 32'(seen), 32'd1);
        end
        chk("hold_data_out", 32'(dout_obs), 32'h9999);
        for (int n = 0; n < 3; n++) begin
            @(negedge clock);
            chk($sformatf("hold_done%0d", n), 32'({rdy_obs, mnr_obs, sel_obs}), 32'h3F);
        end
        nr[0] = 1'b1;
        @(negedge clock);
        chk("hold_release_idle", 32'(rdy_obs), 32'd0);
        @(negedge clock);
        chk("hold_no_reaccess", 32'({rdy_obs, mnr_obs}), 32'h1);

        // Reset in the second ACCESS cycle.
        @(negedge clock);
        address = 16'h8004; memDataIn = 16'h1357; nr[0] = 1'b0;
        @(posedge clock);
        @(negedge clock);
        nr[0] = 1'b1;
        chk("rst_mid_in_access", 32'(mnr_obs), 32'd0);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_select", 32'(sel_obs), 32'hF);
        chk("rst_mid_strobes", 32'({mnr_obs, mnw_obs}), 32'h3);
        chk("rst_mid_ready_error", 32'({rdy_obs, err_obs}), 32'h0);
        chk("rst_mid_data_out", 32'(dout_obs), 32'h0);
        chk("rst_mid_mem_addr_data", {maddr_obs, mdo_obs}, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        repeat (2) begin
            @(negedge clock);
            chk("rst_mid_stays_idle", 32'({rdy_obs, mnr_obs, mnw_obs}), 32'h3);
        end
        do_vec(vecs[1], 11);
`ifdef MEM_CTRL_ACCESS_COUNT_EN
        chk("access_count0_after_reset", cnt0, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
